// File: rtl/pe_mac_drain.sv
// pe_mac_drain
// -----------------------------------------------------------------------------
// Systolic-array processing element. It is a valid-qualified multiply-accumulate
// cell. A operands move west->east and B operands move north->south, each
// through one register. Finished dot products leave through a small ready/valid
// FIFO, so a slow collector does not lose results that arrive back-to-back.
//
// Parameters
//   DATA_W       operand width
//   ACC_W        accumulator / drain width (must be >= 2*DATA_W)
//   DRAIN_DEPTH  drain FIFO entries (>= 1, any value)
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   a_valid_i/a_last_i/a_data_i   A operand, qualifier and end-of-dot-product
//   b_valid_i/b_last_i/b_data_i   B operand, qualifier and end-of-dot-product
//   a_*_o, b_*_o                  registered A/B passthrough (1 cycle)
//   signed_i                      1: two's complement operands, 0: unsigned
//   sat_en_i                      1: clamp accumulator at ACC_W limits, 0: wrap
//   drain_valid_o/_data_o/_sat_o  FIFO head (data/sat read as 0 while empty)
//   drain_ready_i                 collector accepts the head
//   ovf_o                         sticky: a result was dropped on a full FIFO
//   err_o                         sticky: valid or last mismatch between A and B
// -----------------------------------------------------------------------------
module pe_mac_drain #(
    parameter int DATA_W      = 16,
    parameter int ACC_W       = 40,
    parameter int DRAIN_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              a_valid_i,
    input  logic              a_last_i,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              b_valid_i,
    input  logic              b_last_i,
    input  logic [DATA_W-1:0] b_data_i,

    output logic              a_valid_o,
    output logic              a_last_o,
    output logic [DATA_W-1:0] a_data_o,
    output logic              b_valid_o,
    output logic              b_last_o,
    output logic [DATA_W-1:0] b_data_o,

    input  logic              signed_i,
    input  logic              sat_en_i,

    output logic              drain_valid_o,
    output logic [ACC_W-1:0]  drain_data_o,
    output logic              drain_sat_o,
    input  logic              drain_ready_i,

    output logic              ovf_o,
    output logic              err_o
);

    localparam int PROD_W = 2 * DATA_W;
    // Two guard bits: one for the carry of the add, one so that both the
    // signed and the unsigned interpretation fit in a single signed sum.
    localparam int SUM_W  = ACC_W + 2;
    localparam int PTR_W  = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
    localparam int CNT_W  = $clog2(DRAIN_DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DRAIN_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DRAIN_DEPTH);

    // Returns {clamped, value}. The sum is exact, so overflow is detected from
    // its upper bits instead of from carries.
    function automatic logic [ACC_W:0] clamp_acc(
        input logic signed [SUM_W-1:0] sum_in,
        input logic                    is_signed,
        input logic                    sat_en
    );
        logic [ACC_W:0] res;
        res = {1'b0, sum_in[ACC_W-1:0]};
        if (sat_en) begin
            if (is_signed) begin
                // Legal signed range needs bits [ACC_W+1:ACC_W-1] all equal.
                if (sum_in[SUM_W-1:ACC_W-1] != {3{sum_in[SUM_W-1]}}) begin
                    if (sum_in[SUM_W-1])
                        res = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
                    else
                        res = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
                end
            end else begin
                if (sum_in[SUM_W-1])
                    res = {1'b1, {ACC_W{1'b0}}};
                else if (sum_in[ACC_W])
                    res = {1'b1, {ACC_W{1'b1}}};
            end
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    // Accumulator state
    logic [ACC_W-1:0] acc_q;
    logic             sat_acc_q;
    logic             first_q;

    // Drain FIFO state
    logic [ACC_W-1:0] fifo_data [DRAIN_DEPTH];
    logic             fifo_sat  [DRAIN_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    // Datapath
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  prod_ext;
    logic signed [SUM_W-1:0]  acc_ext;
    logic signed [SUM_W-1:0]  sum;
    logic [ACC_W-1:0]         acc_n;
    logic                     sat_hit;
    logic                     sat_acc_n;

    // Control
    logic fire;
    logic last_beat;
    logic err_set;
    logic push_req;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    assign fire      = a_valid_i & b_valid_i;
    // A last mismatch ends the dot product only if both sides agree.
    assign last_beat = a_last_i & b_last_i;
    assign err_set   = (a_valid_i ^ b_valid_i) | (fire & (a_last_i ^ b_last_i));

    // ---- stage 0: multiply, extend, accumulate, clamp (combinational) ----
    always_comb begin
        // Extend the operands to the product width. In unsigned mode the
        // extension is zero. The low PROD_W bits of the signed product are then
        // exact for both modes.
        a_ext    = {{DATA_W{signed_i & a_data_i[DATA_W-1]}}, a_data_i};
        b_ext    = {{DATA_W{signed_i & b_data_i[DATA_W-1]}}, b_data_i};
        prod     = a_ext * b_ext;
        prod_ext = {{(SUM_W-PROD_W){signed_i & prod[PROD_W-1]}}, prod};
        // first_q stands in for a clear, so the first beat of a new dot
        // product starts from zero.
        acc_ext  = first_q ? '0 : {{2{signed_i & acc_q[ACC_W-1]}}, acc_q};
        sum      = acc_ext + prod_ext;
        {sat_hit, acc_n} = clamp_acc(sum, signed_i, sat_en_i);
        sat_acc_n = (~first_q & sat_acc_q) | sat_hit;
    end

    assign push_req = fire & last_beat;
    assign full     = (count == FULL_CNT);
    assign pop      = drain_valid_o & drain_ready_i;
    // While the FIFO is full, a same-cycle pop frees the slot the push needs.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // ---- stage 1: registered passthrough, accumulator, FIFO control ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_valid_o <= 1'b0;
            a_last_o  <= 1'b0;
            a_data_o  <= '0;
            b_valid_o <= 1'b0;
            b_last_o  <= 1'b0;
            b_data_o  <= '0;
            acc_q     <= '0;
            sat_acc_q <= 1'b0;
            first_q   <= 1'b1;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf_o     <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            a_valid_o <= a_valid_i;
            a_last_o  <= a_last_i;
            a_data_o  <= a_data_i;
            b_valid_o <= b_valid_i;
            b_last_o  <= b_last_i;
            b_data_o  <= b_data_i;

            if (fire) begin
                acc_q     <= acc_n;
                sat_acc_q <= sat_acc_n;
                first_q   <= last_beat;
            end

            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);

            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (drop)    ovf_o <= 1'b1;
            if (err_set) err_o <= 1'b1;
        end
    end

    // FIFO storage holds only data, so it has no reset. The head is masked
    // while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_data[wr_ptr] <= acc_n;
            fifo_sat[wr_ptr]  <= sat_acc_n;
        end
    end

    assign drain_valid_o = (count != '0);
    assign drain_data_o  = drain_valid_o ? fifo_data[rd_ptr] : '0;
    assign drain_sat_o   = drain_valid_o & fifo_sat[rd_ptr];

endmodule

// File: tb/tb_pe_mac_drain.sv
// Bench for pe_mac_drain. Two instances share one stimulus: ACC_W=40 and
// ACC_W=32. A behavioural model predicts every output on every cycle, and
// directed literal expectations pin the model.
module tb_pe_mac_drain;

    localparam int DW    = 16;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_valid, a_last, b_valid, b_last;
    logic [DW-1:0] a_data, b_data;
    logic          sgn, sat_en, drain_ready;

    // instance 0: ACC_W=40
    logic          p0_av, p0_al, p0_bv, p0_bl;
    logic [DW-1:0] p0_ad, p0_bd;
    logic          d0_valid, d0_sat, d0_ovf, d0_err;
    logic [39:0]   d0_data;
    // instance 1: ACC_W=32
    logic          p1_av, p1_al, p1_bv, p1_bl;
    logic [DW-1:0] p1_ad, p1_bd;
    logic          d1_valid, d1_sat, d1_ovf, d1_err;
    logic [31:0]   d1_data;

    pe_mac_drain #(.DATA_W(DW), .ACC_W(40), .DRAIN_DEPTH(DEPTH)) u_dut40 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_valid_i(a_valid), .a_last_i(a_last), .a_data_i(a_data),
        .b_valid_i(b_valid), .b_last_i(b_last), .b_data_i(b_data),
        .a_valid_o(p0_av), .a_last_o(p0_al), .a_data_o(p0_ad),
        .b_valid_o(p0_bv), .b_last_o(p0_bl), .b_data_o(p0_bd),
        .signed_i(sgn), .sat_en_i(sat_en),
        .drain_valid_o(d0_valid), .drain_data_o(d0_data), .drain_sat_o(d0_sat),
        .drain_ready_i(drain_ready), .ovf_o(d0_ovf), .err_o(d0_err)
    );

    pe_mac_drain #(.DATA_W(DW), .ACC_W(32), .DRAIN_DEPTH(DEPTH)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .a_valid_i(a_valid), .a_last_i(a_last), .a_data_i(a_data),
        .b_valid_i(b_valid), .b_last_i(b_last), .b_data_i(b_data),
        .a_valid_o(p1_av), .a_last_o(p1_al), .a_data_o(p1_ad),
        .b_valid_o(p1_bv), .b_last_o(p1_bl), .b_data_o(p1_bd),
        .signed_i(sgn), .sat_en_i(sat_en),
        .drain_valid_o(d1_valid), .drain_data_o(d1_data), .drain_sat_o(d1_sat),
        .drain_ready_i(drain_ready), .ovf_o(d1_ovf), .err_o(d1_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. The accumulator is held as a mathematical integer
    // in the current interpretation (signed or unsigned). Overflow is
    // decided by range comparison against the ACC_W limits.
    // ------------------------------------------------------------------
    int     acc_w   [2] = '{40, 32};
    longint m_acc   [2];
    bit     m_first [2];
    bit     m_sat   [2];
    bit     m_ovf   [2];
    bit     m_err   [2];
    longint q_data0[$], q_data1[$];
    bit     q_sat0[$],  q_sat1[$];
    logic   e_av, e_al, e_bv, e_bl;
    logic [DW-1:0] e_ad, e_bd;

    function automatic longint wrap_to(input longint v, input int w, input bit sgn_mode);
        longint m, r;
        m = longint'(1) <<< w;
        r = v % m;
        if (r < 0) r += m;
        if (sgn_mode && r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_first[k] = 1'b1; m_sat[k] = 1'b0;
            m_ovf[k] = 1'b0; m_err[k] = 1'b0;
        end
        q_data0.delete(); q_data1.delete(); q_sat0.delete(); q_sat1.delete();
        e_av = 0; e_al = 0; e_bv = 0; e_bl = 0; e_ad = '0; e_bd = '0;
    endtask

    task automatic model_step(input int k);
        int     w;
        longint m, pa, pb, s, lo, hi;
        bit     hit, last, push, pop, fire;
        w    = acc_w[k];
        m    = longint'(1) <<< w;
        fire = a_valid & b_valid;
        push = 1'b0;
        s    = 0;
        hit  = 1'b0;
        if (a_valid != b_valid) m_err[k] = 1'b1;
        if (fire) begin
            if (a_last != b_last) m_err[k] = 1'b1;
            last = a_last & b_last;
            pa = sgn ? longint'($signed(a_data)) : longint'(a_data);
            pb = sgn ? longint'($signed(b_data)) : longint'(b_data);
            s  = (m_first[k] ? longint'(0) : m_acc[k]) + pa * pb;
            if (sat_en) begin
                lo = sgn ? -(m / 2) : longint'(0);
                hi = sgn ? (m / 2 - 1) : (m - 1);
                if (s > hi) begin s = hi; hit = 1'b1; end
                else if (s < lo) begin s = lo; hit = 1'b1; end
            end else begin
                s = wrap_to(s, w, sgn);
            end
            m_sat[k]   = (m_first[k] ? 1'b0 : m_sat[k]) | hit;
            m_acc[k]   = s;
            m_first[k] = last;
            push       = last;
        end
        if (k == 0) begin
            pop = (q_data0.size() != 0) && drain_ready;
            if (pop) begin void'(q_data0.pop_front()); void'(q_sat0.pop_front()); end
            if (push) begin
                if (q_data0.size() == DEPTH) m_ovf[k] = 1'b1;
                else begin q_data0.push_back(s & (m - 1)); q_sat0.push_back(m_sat[k]); end
            end
        end else begin
            pop = (q_data1.size() != 0) && drain_ready;
            if (pop) begin void'(q_data1.pop_front()); void'(q_sat1.pop_front()); end
            if (push) begin
                if (q_data1.size() == DEPTH) m_ovf[k] = 1'b1;
                else begin q_data1.push_back(s & (m - 1)); q_sat1.push_back(m_sat[k]); end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0);
            model_step(1);
            e_av = a_valid; e_al = a_last; e_ad = a_data;
            e_bv = b_valid; e_bl = b_last; e_bd = b_data;
        end
    end

    task automatic check_inst(input int k, input logic av, input logic al, input logic [DW-1:0] ad,
                              input logic bv, input logic bl, input logic [DW-1:0] bd,
                              input logic dv, input logic [63:0] dd, input logic ds,
                              input logic ovf, input logic err);
        string  p;
        int     sz;
        longint hd;
        bit     hs;
        p  = (k == 0) ? "u40" : "u32";
        sz = (k == 0) ? q_data0.size() : q_data1.size();
        chk({p, ".a_valid_o"}, 64'(av), 64'(e_av));
        chk({p, ".a_last_o"},  64'(al), 64'(e_al));
        chk({p, ".a_data_o"},  64'(ad), 64'(e_ad));
        chk({p, ".b_valid_o"}, 64'(bv), 64'(e_bv));
        chk({p, ".b_last_o"},  64'(bl), 64'(e_bl));
        chk({p, ".b_data_o"},  64'(bd), 64'(e_bd));
        chk({p, ".drain_valid_o"}, 64'(dv), 64'(sz != 0));
        if (sz != 0) begin
            hd = (k == 0) ? q_data0[0] : q_data1[0];
            hs = (k == 0) ? q_sat0[0]  : q_sat1[0];
            chk({p, ".drain_data_o"}, dd, hd);
            chk({p, ".drain_sat_o"},  64'(ds), 64'(hs));
        end
        chk({p, ".ovf_o"}, 64'(ovf), 64'(m_ovf[k]));
        chk({p, ".err_o"}, 64'(err), 64'(m_err[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, p0_av, p0_al, p0_ad, p0_bv, p0_bl, p0_bd,
                       d0_valid, {24'd0, d0_data}, d0_sat, d0_ovf, d0_err);
            check_inst(1, p1_av, p1_al, p1_ad, p1_bv, p1_bl, p1_bd,
                       d1_valid, {32'd0, d1_data}, d1_sat, d1_ovf, d1_err);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus. Inputs change 1 time unit after the rising edge and are
    // consumed at the next rising edge.
    // ------------------------------------------------------------------
    task automatic drive(input logic av, input logic al, input logic [DW-1:0] ad,
                         input logic bv, input logic bl, input logic [DW-1:0] bd);
        a_valid = av; a_last = al; a_data = ad;
        b_valid = bv; b_last = bl; b_data = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic mac(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
        drive(1'b1, last, a, 1'b1, last, b);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " u40 passthrough"}, 64'({p0_av, p0_al, p0_ad, p0_bv, p0_bl, p0_bd}), 64'd0);
        chk({tag, " u40 drain/flags"}, 64'({d0_valid, d0_sat, d0_ovf, d0_err}), 64'd0);
        chk({tag, " u40 drain_data"},  64'(d0_data), 64'd0);
        chk({tag, " u32 passthrough"}, 64'({p1_av, p1_al, p1_ad, p1_bv, p1_bl, p1_bd}), 64'd0);
        chk({tag, " u32 drain/flags"}, 64'({d1_valid, d1_sat, d1_ovf, d1_err}), 64'd0);
        chk({tag, " u32 drain_data"},  64'(d1_data), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = 0; a_last = 0; a_data = '0;
        b_valid = 0; b_last = 0; b_data = '0;
        sgn = 0; sat_en = 0; drain_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Unsigned dot product 3*4 + 5*6 + 7*8 = 98
        mac(16'd3, 16'd4, 1'b0);
        mac(16'd5, 16'd6, 1'b0);
        mac(16'd7, 16'd8, 1'b1);
        chk("t1 drain_valid", 64'(d0_valid), 64'd1);
        chk("t1 drain_data",  64'(d0_data),  64'h62);
        chk("t1 drain_sat",   64'(d0_sat),   64'd0);
        chk("t1 a_data_o",    64'(p0_ad),    64'd7);
        chk("t1 b_data_o",    64'(p0_bd),    64'd8);
        chk("t1 u32 data",    64'(d1_data),  64'h62);
        idle(2);

        // Signed back-to-back single-beat products: -6 then -20
        sgn = 1'b1;
        mac(16'hFFFE, 16'd3, 1'b1);
        chk("t2 first data",  64'(d0_data), 64'hFF_FFFF_FFFA);
        mac(16'd4, 16'hFFFB, 1'b1);
        chk("t2 second valid", 64'(d0_valid), 64'd1);
        chk("t2 second data",  64'(d0_data),  64'hFF_FFFF_FFEC);
        chk("t2 u32 second",   64'(d1_data),  64'hFFFF_FFEC);
        idle(2);

        // Signed saturation: 3 * 0x3FFF0001 exceeds the 32-bit range
        sat_en = 1'b1;
        mac(16'h7FFF, 16'h7FFF, 1'b0);
        mac(16'h7FFF, 16'h7FFF, 1'b0);
        mac(16'h7FFF, 16'h7FFF, 1'b1);
        chk("t3 u32 sat data", 64'(d1_data), 64'h7FFF_FFFF);
        chk("t3 u32 sat flag", 64'(d1_sat),  64'd1);
        chk("t3 u40 data",     64'(d0_data), 64'h00_BFFD_0003);
        chk("t3 u40 sat flag", 64'(d0_sat),  64'd0);
        idle(2);
        sat_en = 1'b0;
        mac(16'h7FFF, 16'h7FFF, 1'b0);
        mac(16'h7FFF, 16'h7FFF, 1'b0);
        mac(16'h7FFF, 16'h7FFF, 1'b1);
        chk("t3 u32 wrap data", 64'(d1_data), 64'hBFFD_0003);
        chk("t3 u32 wrap flag", 64'(d1_sat),  64'd0);
        idle(2);
        sgn = 1'b0;

        // FIFO full, then a push and a pop in the same cycle: no drop
        drain_ready = 1'b0;
        mac(16'd10, 16'd1, 1'b1);
        mac(16'd20, 16'd1, 1'b1);
        chk("t4 full head", 64'(d0_data), 64'd10);
        chk("t4 full ovf",  64'(d0_ovf),  64'd0);
        drain_ready = 1'b1;
        mac(16'd30, 16'd1, 1'b1);
        chk("t4 push+pop ovf",  64'(d0_ovf),  64'd0);
        chk("t4 push+pop head", 64'(d0_data), 64'd20);
        drain_ready = 1'b0;
        idle(1);
        chk("t4 held head", 64'(d0_data), 64'd20);
        drain_ready = 1'b1;
        idle(1);
        chk("t4 next head", 64'(d0_data), 64'd30);
        idle(1);
        chk("t4 empty", 64'(d0_valid), 64'd0);

        // Overflow: third result is dropped
        drain_ready = 1'b0;
        mac(16'd1, 16'd1, 1'b1);
        mac(16'd2, 16'd1, 1'b1);
        chk("t5 ovf before", 64'(d0_ovf), 64'd0);
        mac(16'd3, 16'd1, 1'b1);
        chk("t5 ovf u40", 64'(d0_ovf), 64'd1);
        chk("t5 ovf u32", 64'(d1_ovf), 64'd1);
        chk("t5 head",    64'(d0_data), 64'd1);
        drain_ready = 1'b1;
        idle(1);
        chk("t5 pop 2", 64'(d0_data), 64'd2);
        idle(1);
        chk("t5 empty",       64'(d0_valid), 64'd0);
        chk("t5 ovf sticky",  64'(d0_ovf),   64'd1);

        // Protocol errors: a lone A valid leaves the accumulator untouched
        chk("t6 err before", 64'(d0_err), 64'd0);
        mac(16'd2, 16'd3, 1'b0);
        drive(1'b1, 1'b0, 16'd100, 1'b0, 1'b0, 16'd0);
        chk("t6 err set", 64'(d0_err), 64'd1);
        mac(16'd4, 16'd5, 1'b1);
        chk("t6 result", 64'(d0_data), 64'd26);
        // Last mismatch: the beat counts as non-last, so the next beat adds on
        drive(1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 16'd3);
        mac(16'd1, 16'd1, 1'b1);
        chk("t6 mismatch result", 64'(d0_data), 64'd7);
        idle(3);
        chk("t6 err sticky", 64'(d1_err), 64'd1);

        // Reset mid dot product, with one FIFO entry pending
        drain_ready = 1'b0;
        mac(16'd1, 16'd1, 1'b1);
        mac(16'd5, 16'd5, 1'b0);
        mac(16'd6, 16'd6, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("t7 async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain_ready = 1'b1;
        idle(1);
        mac(16'd2, 16'd2, 1'b1);
        chk("t7 result valid", 64'(d0_valid), 64'd1);
        chk("t7 result data",  64'(d0_data),  64'd4);
        chk("t7 u32 data",     64'(d1_data),  64'd4);
        chk("t7 flags",        64'({d0_sat, d0_ovf, d0_err}), 64'd0);
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
